// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one Booth multiplier core among NREQ requesters.
// Optional watchdog on the core response is enabled with `define MUL_TIMEOUT_EN.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_product,
  output logic              rsp_err,
  output logic              core_start,
  output logic [W-1:0]      core_a,
  output logic [W-1:0]      core_b,
  input  logic              core_done,
  input  logic [2*W-1:0]    core_product,
  output logic              busy
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("booth_mul_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;

  // Circular search starting just after the previous winner.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      req_ready   <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      core_start  <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
`ifdef MUL_TIMEOUT_EN
      wd_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      req_ready  <= '0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            req_ready[grant_idx] <= 1'b1;
            core_a     <= req_a[int'(grant_idx)*W +: W];
            core_b     <= req_b[int'(grant_idx)*W +: W];
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b1;
`ifdef MUL_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          // A done pulse alongside our own start pulse cannot belong to this operation.
          if (core_done && !core_start) begin
            rsp_product <= core_product;
            rsp_valid   <= 1'b1;
`ifdef MUL_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            state       <= RESP;
          end
`ifdef MUL_TIMEOUT_EN
          else if (wd_cnt == CW'(TIMEOUT)) begin
            rsp_product <= '0;
            rsp_valid   <= 1'b1;
            err_q       <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a fixed-latency signed core model.
module tb_booth_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int L    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_err;
  logic              core_start;
  logic [W-1:0]      core_a;
  logic [W-1:0]      core_b;
  logic              core_done;
  logic [2*W-1:0]    core_product;
  logic              busy;

  logic              model_done = 1'b0;
  logic [2*W-1:0]    model_prod = '0;
  logic              stray_done = 1'b0;
  bit                core_en = 1'b1;
  int                rem = 0;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_bad = 0;

  assign core_done    = model_done | stray_done;
  assign core_product = stray_done ? 16'hDEAD : model_prod;

  booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_product(core_product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Signed core: done is high in the L-th cycle after the start cycle.
  always @(negedge clk) begin
    logic signed [2*W-1:0] pa, pb;
    model_done = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) model_done = 1'b1;
    end
    if (core_start && core_en) begin
      pa = $signed(core_a);
      pb = $signed(core_b);
      model_prod = pa * pb;
      rem = L;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (req_ready == '0 && n < max) begin
      tick();
      n++;
    end
    chk("ready_seen", 32'(req_ready != '0), 1);
  endtask

  task automatic wait_rsp(input int max);
    int n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
    chk("rsp_seen", 32'(rsp_valid), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int s0;
    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_ops", {16'h0, core_a, core_b}, 0);
    chk("rst_rsp", {13'h0, rsp_err, rsp_id, rsp_product}, 0);
    rst = 1'b0;

    // Single request: 3*5, latency checks
    req_a[7:0] = 8'd3; req_b[7:0] = 8'd5; req_valid = 4'b0001;
    wait_ready(10);
    t0 = cyc;
    chk("t1_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();
    chk("t1_ready_pulse", 32'(req_ready), 0);
    chk("t1_start", 32'(core_start), 1);
    tick();
    chk("t1_start_once", 32'(core_start), 0);
    chk("t1_ops", {16'h0, core_a, core_b}, 32'h0305);
    wait_rsp(20);
    chk("t1_latency", 32'(cyc - t0), 32'(L + 2));
    chk("t1_rsp", {13'h0, rsp_err, rsp_id, rsp_product}, 32'h0000_000F);
    tick();
    chk("t1_idle", {30'h0, busy, rsp_valid}, 0);

    // Signed pass-through: -3 * 7 on requester 2
    req_a[23:16] = 8'hFD; req_b[23:16] = 8'h07; req_valid = 4'b0100;
    wait_ready(10);
    chk("t2_grant", 32'(req_ready), 32'h4);
    req_valid = '0;
    tick(); tick(); tick();
    chk("t2_ops_wait", {16'h0, core_a, core_b}, 32'hFD07);
    chk("t2_busy", 32'(busy), 1);
    wait_rsp(20);
    chk("t2_rsp", {13'h0, rsp_err, rsp_id, rsp_product}, 32'h0002_FFEB);
    tick();

    // Fairness from reset: all requesting
    do_reset();
    req_a = {8'd4, 8'd3, 8'd2, 8'd1}; req_b = {8'd1, 8'd1, 8'd1, 8'd1};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_ready(10);
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k == 5) req_valid = '0;
      wait_rsp(20);
      chk("fair_rsp", {rsp_id, rsp_product}, {IDW'(k % 4), 16'(k % 4 + 1)});
      tick();
    end

    // Back-pressure with requester 3 pending and a stray done during RESP
    rsp_ready = 1'b0;
    req_a[15:8] = 8'h12; req_b[15:8] = 8'h03; req_valid = 4'b0010;
    wait_ready(10);
    chk("bp_grant", 32'(req_ready), 32'h2);
    req_a[31:24] = 8'd2; req_b[31:24] = 8'd2; req_valid = 4'b1000;
    wait_rsp(20);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      chk("bp_hold", {rsp_valid, rsp_id, rsp_product, req_ready, core_start},
          {1'b1, 2'd1, 16'h0036, 4'b0000, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle", {30'h0, busy, rsp_valid}, 0);
    tick();
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    wait_rsp(20);
    chk("bp_next_rsp", {rsp_id, rsp_product}, {2'd3, 16'h0004});
    tick();

    // Reset during WAIT, then late done pulses in IDLE
    req_a[7:0] = 8'd3; req_b[7:0] = 8'd5; req_valid = 4'b0001;
    wait_ready(10);
    req_valid = '0;
    tick(); tick();
    do_reset();
    chk("mr_state", {busy, rsp_valid, req_ready, core_start}, 0);
    chk("mr_data", {core_a, core_b, rsp_product}, 0);
    for (int i = 0; i < 6; i++) begin
      stray_done = (i == 4);
      tick();
      chk("mr_quiet", {busy, rsp_valid, rsp_product}, 0);
    end
    stray_done = 1'b0;
    req_valid = 4'b1001;
    wait_ready(10);
    chk("mr_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    wait_rsp(20);
    tick();

    // Core that never answers
    core_en = 1'b0;
    req_valid = 4'b0001;
    wait_ready(10);
    req_valid = '0;
    tick();
    s0 = cyc;
`ifdef MUL_TIMEOUT_EN
    wait_rsp(40);
    chk("to_latency", 32'(cyc - s0), 17);
    chk("to_rsp", {13'h0, rsp_err, rsp_id, rsp_product}, 32'h0004_0000);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("to_hang", {busy, rsp_valid}, 2'b10);
`endif
    do_reset();
    chk("to_reset", {busy, rsp_valid, rsp_err}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one Booth multiplier core among NREQ requesters.
- Selects a requester by round-robin, latches its operands, and starts the core.
- Waits for the core's done pulse, then returns the product tagged with the requester's ID over a valid/ready response channel.
- Sits between the requester clients and a single multiplier instance, and owns all sequencing of that core.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- W, 8: operand width; the product is 2*W bits.
- IDW, $clog2(NREQ): width of the requester ID (localparam).
- TIMEOUT, 16: watchdog limit in cycles. Used only with MUL_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*W  packed multiplicands; requester i uses [i*W +: W].
- req_b  in  NREQ*W  packed multipliers; same packing.
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  IDW  index of the requester that was served.
- rsp_product  out  2*W  product.
- rsp_err  out  1  result invalid (timeout).
- core_start  out  1  one-cycle start pulse to the core.
- core_a  out  W  operand a to the core.
- core_b  out  W  operand b to the core.
- core_done  in  1  one-cycle pulse from the core; core_product is valid in that cycle.
- core_product  in  2*W  core result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:

Reset:
- Reset is synchronous.
- state=IDLE; req_ready=0; rsp_valid=0; rsp_err=0; rsp_id=0; rsp_product=0; core_start=0; core_a=0; core_b=0; busy=0.
- last_grant=NREQ-1, so requester 0 has first priority.

States:
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise grant the first asserted req_valid, searching circularly from last_grant+1.
  - Register req_ready[g]=1 for exactly one cycle.
  - Latch req_a[g] and req_b[g] into core_a and core_b, and g into the ID register.
  - Update last_grant=g, then go to ISSUE.
- ISSUE:
  - core_start=1 for this cycle only; go to WAIT.
- WAIT:
  - core_a and core_b stay stable throughout.
  - On core_done: latch core_product into rsp_product, set rsp_valid=1 and rsp_err=0, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_product and rsp_err are held until rsp_valid&rsp_ready.
  - On that handshake: next cycle rsp_valid=0, state=IDLE.

Handshake and timing:
- A request is accepted on the cycle req_valid[i]&req_ready[i] is high.
- A requester may deassert req_valid before it is granted; the request is simply dropped.
- req_valid is sampled only in IDLE.
- Timing with core latency L (start to done) and the request accepted in cycle T:
  - core_start in cycle T+1.
  - rsp_valid in cycle T+2+L.
- Minimum spacing between accepts is L+4 cycles when rsp_ready is tied high.

Boundary conditions:
- core_done outside WAIT is ignored and does not corrupt rsp_product.
- core_done coincident with core_start is ignored; the core's latency is ≥1.
- Any number of simultaneous requests produces exactly one grant per transaction.
- Round-robin guarantees every persistent requester is served within NREQ transactions.
- Operands and product pass through unmodified; signedness is the core's concern.
- Reset mid-operation drops any pending result silently.
  - The core shares rst, so no stale core_done is expected.
  - If a stale core_done arrives anyway, it is ignored in IDLE.

Optional Feature:

MUL_TIMEOUT_EN
- Defined:
  - A counter is cleared in ISSUE and increments each cycle in WAIT.
  - If it reaches TIMEOUT with no core_done: rsp_valid=1, rsp_err=1, rsp_product=0, go to RESP.
  - A late core_done after that point is ignored.
  - core_done on the same cycle as the timeout takes priority as a normal result.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - rsp_err is tied to 0.

Test Plan:
1. Single request. Req0 with a=3, b=5; core model L=4; rsp_ready=1 → req_ready[0] pulses one cycle; a single core_start one cycle later; rsp_valid at T+6 with rsp_id=0, rsp_product=16'h000F, rsp_err=0.
2. Signed pass-through. Req2 with a=8'hFD (-3), b=8'h07 → core_a=8'hFD and core_b=8'h07 held through WAIT; rsp_product=16'hFFEB; rsp_id=2.
3. Fairness. All four req_valid held high → grant order 0,1,2,3,0,1; never two req_ready bits in one cycle.
4. Back-pressure. rsp_ready held low for 5 cycles after rsp_valid → response held stable; no req_ready and no core_start until the handshake; IDLE is re-entered the cycle after rsp_ready rises.
5. Mid-operation reset. rst pulsed during WAIT, then core_done pulsed in IDLE → all outputs return to reset values; no rsp_valid; the next simultaneous req0/req3 grants req0.
6. Timeout. With MUL_TIMEOUT_EN and TIMEOUT=16, core_done never asserted → rsp_valid with rsp_err=1 and rsp_product=0, 17 cycles after core_start. Without the macro: no response, busy stays high.
